// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the bus gate arbiter: controller states,
// source count, source index names and a one-hot encoding helper.
package bus_arb_pkg;

  localparam int N_SRC = 4;

  localparam logic [1:0] SRC_PC     = 2'd0;
  localparam logic [1:0] SRC_MDR    = 2'd1;
  localparam logic [1:0] SRC_ALU    = 2'd2;
  localparam logic [1:0] SRC_MARMUX = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

  // One-hot bus select for a source index.
  function automatic logic [N_SRC-1:0] src_onehot(input logic [1:0] idx);
    return (N_SRC)'(1) << idx;
  endfunction

endpackage

// File: rtl/bus_gate_arbiter_rr_pick4.sv
// Combinational round-robin picker for four sources. The winner is the first
// requesting source found scanning upward from last+1, wrapping modulo 4, so
// the previous winner (last) has the lowest priority.
module rr_pick4
  import bus_arb_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [1:0]       last,
  output logic             valid,
  output logic [1:0]       winner
);

  // Scan from farthest to nearest so the nearest requester after last wins.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    valid  = 1'b0;
    winner = last;
    for (int k = N_SRC; k >= 1; k--) begin
      if (req[last + 2'(k)]) begin
        valid  = 1'b1;
        winner = last + 2'(k);
      end
    end
  end

endmodule

// File: rtl/bus_gate_arbiter.sv
// bus_gate_arbiter: round-robin owner of the 16-bit datapath bus. Produces a
// registered one-hot gate select, holds the grant while the owner keeps
// requesting and always inserts a turnaround before the bus changes hands.
// Optional feature macro: BUS_ARB_PREEMPT_EN enables the MAX_HOLD counter,
// forced release of a long-holding owner and the preempt pulse.
module bus_gate_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [N_SRC-1:0] req,
  output logic [N_SRC-1:0] gate_sel,
  output logic [1:0]       owner,
  output logic             bus_idle,
  output logic             preempt
);

  arb_state_e       state;
  arb_state_e       state_next;
  logic [1:0]       last;
  logic             pick_valid;
  logic [1:0]       pick_winner;
  logic             force_rel;

  logic [N_SRC-1:0] gate_next;
  logic [1:0]       owner_next;
  logic [1:0]       last_next;
  logic             preempt_next;

  // Round-robin picker; only consulted while the bus is idle.
  rr_pick4 u_pick (
    .req    (req),
    .last   (last),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

`ifdef BUS_ARB_PREEMPT_EN
  logic [7:0] hold_cnt;
  logic       others_wait;

  assign others_wait = |(req & ~src_onehot(owner));
  // A dropping owner always takes the normal release path, never the forced one.
  assign force_rel   = (state == GRANT) && req[owner] && others_wait &&
                       (hold_cnt == 8'(MAX_HOLD - 1));

  // Hold counter: cleared on a new grant, counts GRANT cycles, saturates at MAX_HOLD.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hold_cnt <= '0;
    end else if (state == IDLE && pick_valid) begin
      hold_cnt <= '0;
    end else if (state == GRANT && hold_cnt != 8'(MAX_HOLD)) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end
`else
  logic [7:0] unused_max_hold;

  assign force_rel       = 1'b0;
  assign unused_max_hold = 8'(MAX_HOLD);
`endif

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: grant from IDLE, release from GRANT, TURN lasts one cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (pick_valid) state_next = GRANT;
      GRANT:   if (!req[owner] || force_rel) state_next = TURN;
      TURN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: next values of the registered bus select, owner and pulse.
  always_comb begin
    gate_next    = gate_sel;
    owner_next   = owner;
    last_next    = last;
    preempt_next = 1'b0;
    unique case (state)
      IDLE: begin
        gate_next = '0;
        if (pick_valid) begin
          gate_next  = src_onehot(pick_winner);
          owner_next = pick_winner;
          last_next  = pick_winner;
        end
      end
      GRANT: begin
        if (!req[owner]) begin
          gate_next = '0;
        end else if (force_rel) begin
          gate_next    = '0;
          preempt_next = 1'b1;
        end
      end
      TURN:    gate_next = '0;
      default: gate_next = '0;
    endcase
  end

  // Output registers; reset leaves source 0 with top priority (last = 3).
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      gate_sel <= '0;
      owner    <= SRC_PC;
      last     <= SRC_MARMUX;
      bus_idle <= 1'b1;
      preempt  <= 1'b0;
    end else begin
      gate_sel <= gate_next;
      owner    <= owner_next;
      last     <= last_next;
      bus_idle <= (gate_next == '0);
      preempt  <= preempt_next;
    end
  end

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Directed bench for bus_gate_arbiter with MAX_HOLD = 4. Inputs change 1 ns
// after a rising edge; outputs are sampled at that point, i.e. they reflect
// the edge just taken. A background monitor checks the per-cycle invariants.
// Expectations for the forced-release cases follow BUS_ARB_PREEMPT_EN.
module tb_bus_gate_arbiter;
  import bus_arb_pkg::*;

  localparam int unsigned MAX_HOLD = 4;

  logic       Clk   = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] req   = 4'b0000;
  logic [3:0] gate_sel;
  logic [1:0] owner;
  logic       bus_idle;
  logic       preempt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  bus_gate_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .req      (req),
    .gate_sel (gate_sel),
    .owner    (owner),
    .bus_idle (bus_idle),
    .preempt  (preempt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Count zero-select samples until a grant appears, bounded to 8 cycles.
  task automatic wait_grant(output int zeros);
    zeros = 0;
    for (int k = 0; k < 8 && gate_sel == 4'b0000; k++) begin
      zeros++;
      tick();
    end
    check("grant_seen", 32'(gate_sel != 4'b0000), 1);
  endtask

  // Per-cycle invariants: one-hot-or-zero, bus_idle consistency, and no
  // direct handover from one owner to another without a zero cycle.
  logic [3:0] prev_gate = 4'b0000;
  always @(posedge Clk) begin
    #2;
    check("inv_onehot0", 32'($onehot0(gate_sel)), 1);
    check("inv_bus_idle", 32'(bus_idle), 32'(gate_sel == 4'b0000));
    check("inv_handover",
          32'(prev_gate == 4'b0000 || gate_sel == 4'b0000 || gate_sel == prev_gate), 1);
`ifndef BUS_ARB_PREEMPT_EN
    check("inv_no_preempt", 32'(preempt), 0);
`endif
    prev_gate = gate_sel;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    int zeros;
    int o;

    // ---- Reset values --------------------------------------------------
    tick();
    check("rst_gate", 32'(gate_sel), 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_idle", 32'(bus_idle), 1);
    check("rst_preempt", 32'(preempt), 0);
    Reset = 1'b0;
    tick();

    // ---- Basic grant, release, turnaround ------------------------------
    req = 4'b1010;                     // last=3: scan 0,1 -> source 1
    tick();
    check("t1_gate", 32'(gate_sel), 32'(4'b0010));
    check("t1_owner", 32'(owner), 1);
    check("t1_busy", 32'(bus_idle), 0);
    tick();
    check("t1_hold", 32'(gate_sel), 32'(4'b0010));
    req = 4'b1000;                     // owner drops
    tick();
    check("t1_turn", 32'(gate_sel), 0);
    check("t1_turn_idle", 32'(bus_idle), 1);
    tick();
    check("t1_idle", 32'(gate_sel), 0);
    tick();
    check("t1_next_gate", 32'(gate_sel), 32'(4'b1000));
    check("t1_next_owner", 32'(owner), 3);
    req = 4'b0000;
    repeat (3) tick();

    // ---- Full contention, each owner drops after 2 cycles --------------
    // From a release sampled at edge t, the next grant appears after t+2.
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      o = order[i];
      wait_grant(zeros);
      if (i > 0) check("t2_gap", 32'(zeros), 2);
      check("t2_gate", 32'(gate_sel), 32'(1) << o);
      check("t2_owner", 32'(owner), 32'(o));
      tick();
      check("t2_hold", 32'(gate_sel), 32'(1) << o);
      req[o] = 1'b0;
      tick();
      check("t2_turn", 32'(gate_sel), 0);
      req[o] = 1'b1;
    end
    req = 4'b0000;
    repeat (3) tick();

    // ---- Long hold with a competing request (last=0 here) --------------
    req = 4'b0001;
    tick();
    check("t3_gate_c1", 32'(gate_sel), 32'(4'b0001));
    req = 4'b0101;
    for (int c = 2; c <= 4; c++) begin
      tick();
      check("t3_gate_hold", 32'(gate_sel), 32'(4'b0001));
      check("t3_no_preempt", 32'(preempt), 0);
    end
`ifdef BUS_ARB_PREEMPT_EN
    tick();
    check("t3_forced_gate", 32'(gate_sel), 0);
    check("t3_preempt", 32'(preempt), 1);
    tick();
    check("t3_idle_gate", 32'(gate_sel), 0);
    check("t3_preempt_end", 32'(preempt), 0);
    tick();
    check("t3_new_gate", 32'(gate_sel), 32'(4'b0100));
    check("t3_new_owner", 32'(owner), 2);
    req = 4'b0000;
    repeat (3) tick();

    // Owner drop coinciding with the timeout is a normal release (last=2).
    req = 4'b0101;                     // scan 3,0 -> source 0
    tick();
    check("t3b_gate", 32'(gate_sel), 32'(4'b0001));
    repeat (3) tick();
    check("t3b_hold", 32'(gate_sel), 32'(4'b0001));
    req = 4'b0100;
    tick();
    check("t3b_turn", 32'(gate_sel), 0);
    check("t3b_no_preempt", 32'(preempt), 0);
    repeat (2) tick();
    check("t3b_next", 32'(gate_sel), 32'(4'b0100));
`else
    for (int c = 0; c < 6; c++) begin
      tick();
      check("t3_keep_gate", 32'(gate_sel), 32'(4'b0001));
      check("t3_keep_no_preempt", 32'(preempt), 0);
    end
    req = 4'b0100;
    tick();
    check("t3_turn", 32'(gate_sel), 0);
    repeat (2) tick();
    check("t3_new_gate", 32'(gate_sel), 32'(4'b0100));
    check("t3_new_owner", 32'(owner), 2);
`endif
    req = 4'b0000;
    repeat (3) tick();

    // ---- Asynchronous reset mid-grant (last=2 here) --------------------
    req = 4'b0010;
    tick();
    check("t4_pre_gate", 32'(gate_sel), 32'(4'b0010));
    @(posedge Clk);
    #3;
    Reset = 1'b1;
    #1;
    check("t4_async_gate", 32'(gate_sel), 0);
    check("t4_async_idle", 32'(bus_idle), 1);
    check("t4_async_owner", 32'(owner), 0);
    req = 4'b1000;
    tick();
    Reset = 1'b0;
    check("t4_held_gate", 32'(gate_sel), 0);
    tick();
    check("t4_gate", 32'(gate_sel), 32'(4'b1000));
    check("t4_owner", 32'(owner), 3);
    check("t4_busy", 32'(bus_idle), 0);

    // Reset restores last=3, so source 0 beats source 3.
    Reset = 1'b1;
    req   = 4'b1001;
    tick();
    Reset = 1'b0;
    tick();
    check("t4_prio_gate", 32'(gate_sel), 32'(4'b0001));
    check("t4_prio_owner", 32'(owner), 0);

    // ---- Random request run; invariants checked by the monitor ---------
    for (int c = 0; c < 300; c++) begin
      req = 4'($urandom_range(0, 15));
      tick();
    end
    req = 4'b0000;
    repeat (4) tick();
    check("end_idle", 32'(bus_idle), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
